// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB and raises
// the datapath strobes and selects for each step.
// Optional interrupt support is compiled in with `define CONTROL_FSM_IRQ_EN
// (adds irq_i/irq_ack_o, the IE flag and the IRQ state).
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | instruction read; waits for mem_ack_i, then loads IR and PC+1
// DECODE  | one idle cycle for the datapath to decode IR
// EXEC    | ALU op, address calc, branch/BL/RET, or halt by class
// MEM     | load/store access; holds until mem_ack_i
// WB      | ALU result written to the register file
// IRQ     | save PC to LR, jump to vector, clear IE (IRQ build only)
// HALT    | idle; left by reset or, in the IRQ build, an enabled interrupt
module control_fsm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] ir_i,
    input  logic [3:0]  flags_i,
    input  logic        mem_ack_i,
`ifdef CONTROL_FSM_IRQ_EN
    input  logic        irq_i,
    output logic        irq_ack_o,
`endif
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_we_o,
    output logic        alu_we_o,
    output logic        alu_en_o,
    output logic        lr_we_o,
    output logic        status_reg_en_o,
    output logic        imm_sel_o,
    output logic [2:0]  pc_sel_o,
    output logic [1:0]  rw_sel_o,
    output logic [1:0]  op2_sel_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_IRQ     = 3'd5,
        S_HALT    = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    state_t     state_q, state_d, fetch_next;
    logic [2:0] op_class;
    logic       branch_taken;
    logic       unused_ir_bits;

`ifdef CONTROL_FSM_IRQ_EN
    logic       ie_q, ie_d;
`endif

    assign op_class       = ir_i[15:13];
    assign unused_ir_bits = ^{ir_i[12], ir_i[8:0]};
    assign state_o        = rst_i ? 3'd0 : state_q;

    // Bcc condition from {N,Z,C,V}; even codes above zero are the negated forms
    always_comb begin
        branch_taken = 1'b0;
        case (ir_i[11:9])
            3'd0: branch_taken = 1'b1;
            3'd1: branch_taken = flags_i[2];
            3'd2: branch_taken = ~flags_i[2];
            3'd3: branch_taken = flags_i[1];
            3'd4: branch_taken = ~flags_i[1];
            3'd5: branch_taken = flags_i[3];
            3'd6: branch_taken = ~flags_i[3];
            3'd7: branch_taken = flags_i[0];
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state and output decode; reset overrides everything so an aborted
    // access never produces a register, PC or LR write
    always_comb begin
        state_d         = state_q;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        reg_we_o        = 1'b0;
        alu_we_o        = 1'b0;
        alu_en_o        = 1'b0;
        lr_we_o         = 1'b0;
        status_reg_en_o = 1'b0;
        imm_sel_o       = 1'b0;
        pc_sel_o        = 3'b000;
        rw_sel_o        = 2'b00;
        op2_sel_o       = 2'b00;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
`ifdef CONTROL_FSM_IRQ_EN
        ie_d            = ie_q;
        irq_ack_o       = 1'b0;
        fetch_next      = (irq_i && ie_q) ? S_IRQ : S_FETCH;
`else
        fetch_next      = S_FETCH;
`endif

        case (state_q)
            S_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ack_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op_class)
                    3'b000, 3'b001: begin
                        alu_we_o        = 1'b1;
                        status_reg_en_o = 1'b1;
                        if (op_class[0]) begin
                            imm_sel_o = 1'b1;
                            op2_sel_o = 2'b01;
                        end
                        state_d = S_WB;
                    end
                    3'b010, 3'b011: begin
                        alu_we_o  = 1'b1;
                        imm_sel_o = 1'b1;
                        op2_sel_o = 2'b01;
                        state_d   = S_MEM;
                    end
                    3'b100: begin
                        if (branch_taken) begin
                            pc_we_o  = 1'b1;
                            pc_sel_o = 3'b001;
                        end
                        state_d = fetch_next;
                    end
                    3'b101: begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = 3'b001;
                        lr_we_o  = 1'b1;
                        state_d  = fetch_next;
                    end
                    3'b110: begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = 3'b010;
`ifdef CONTROL_FSM_IRQ_EN
                        if (ir_i[0]) ie_d = 1'b1;
`endif
                        state_d  = fetch_next;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                alu_en_o    = 1'b1;
                mem_read_o  = ~op_class[0];
                mem_write_o = op_class[0];
                if (mem_ack_i) begin
                    if (!op_class[0]) begin
                        reg_we_o = 1'b1;
                        rw_sel_o = 2'b01;
                    end
                    state_d = fetch_next;
                end
            end
            S_WB: begin
                reg_we_o = 1'b1;
                alu_en_o = 1'b1;
                state_d  = fetch_next;
            end
`ifdef CONTROL_FSM_IRQ_EN
            S_IRQ: begin
                lr_we_o   = 1'b1;
                pc_we_o   = 1'b1;
                pc_sel_o  = 3'b011;
                irq_ack_o = 1'b1;
                ie_d      = 1'b0;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                if (irq_i && ie_q) state_d = S_IRQ;
            end
`else
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase

        if (rst_i) begin
            state_d         = S_FETCH;
            ir_we_o         = 1'b0;
            pc_we_o         = 1'b0;
            reg_we_o        = 1'b0;
            alu_we_o        = 1'b0;
            alu_en_o        = 1'b0;
            lr_we_o         = 1'b0;
            status_reg_en_o = 1'b0;
            imm_sel_o       = 1'b0;
            pc_sel_o        = 3'b000;
            rw_sel_o        = 2'b00;
            op2_sel_o       = 2'b00;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
`ifdef CONTROL_FSM_IRQ_EN
            ie_d            = 1'b1;
            irq_ack_o       = 1'b0;
`endif
        end
    end

    // State (and interrupt enable) registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
`ifdef CONTROL_FSM_IRQ_EN
            ie_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
`ifdef CONTROL_FSM_IRQ_EN
            ie_q    <= ie_d;
`endif
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: an instruction-level model predicts every output each
// cycle, and directed scenarios pin key cycles with literal expectations.
module tb_control_fsm;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] ir    = 16'h0000;
    logic [3:0]  flags = 4'h0;
    logic        ack   = 1'b0;
    logic ir_we, pc_we, reg_we, alu_we, alu_en, lr_we, sr_en, imm_sel, mem_read, mem_write;
    logic [2:0]  pc_sel;
    logic [1:0]  rw_sel, op2_sel;
    logic [2:0]  state;
    logic        irq_ack_w;
    logic [20:0] dut_v;

    int n_checks = 0;
    int n_errors = 0;

    // instruction-level model: position within instruction, halted, in-irq, IE
    int m_pos  = 0;
    bit m_halt = 1'b0;
    bit m_irq  = 1'b0;
    bit m_ie   = 1'b1;

`ifdef CONTROL_FSM_IRQ_EN
    logic irq = 1'b0;
    logic irq_ack;
    assign irq_ack_w = irq_ack;
`else
    assign irq_ack_w = 1'b0;
`endif

    control_fsm dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ir_i            (ir),
        .flags_i         (flags),
        .mem_ack_i       (ack),
`ifdef CONTROL_FSM_IRQ_EN
        .irq_i           (irq),
        .irq_ack_o       (irq_ack),
`endif
        .ir_we_o         (ir_we),
        .pc_we_o         (pc_we),
        .reg_we_o        (reg_we),
        .alu_we_o        (alu_we),
        .alu_en_o        (alu_en),
        .lr_we_o         (lr_we),
        .status_reg_en_o (sr_en),
        .imm_sel_o       (imm_sel),
        .pc_sel_o        (pc_sel),
        .rw_sel_o        (rw_sel),
        .op2_sel_o       (op2_sel),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .state_o         (state)
    );

    assign dut_v = {irq_ack_w, ir_we, pc_we, reg_we, alu_we, alu_en, lr_we, sr_en, imm_sel,
                    mem_read, mem_write, pc_sel, rw_sel, op2_sel, state};

    always #5 clk = ~clk;

    function automatic bit irq_now();
`ifdef CONTROL_FSM_IRQ_EN
        return irq;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit cond_true(input logic [2:0] code, input logic [3:0] f);
        logic [7:0] t;
        t = {f[0], ~f[3], f[3], ~f[1], f[1], ~f[2], f[2], 1'b1};
        return t[code];
    endfunction

    // visible state number implied by where the model sits in the instruction
    function automatic logic [2:0] exp_state();
        if (m_irq)  return 3'd5;
        if (m_halt) return 3'd6;
        if (m_pos < 3) return 3'(m_pos);
        return (ir[15:14] == 2'b00) ? 3'd4 : 3'd3;
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [2:0] cls, st, pcs;
        logic [1:0] rws, op2;
        logic iack, irwe, pcwe, rgwe, aluwe, aluen, lrwe, srn, imm, mr, mw;
        cls = ir[15:13];
        st  = exp_state();
        {iack, irwe, pcwe, rgwe, aluwe, aluen, lrwe, srn, imm, mr, mw} = '0;
        pcs = 3'd0; rws = 2'd0; op2 = 2'd0;
        if (rst) return '0;
        if (st == 3'd0) begin
            mr = 1'b1;
            if (ack) begin irwe = 1'b1; pcwe = 1'b1; end
        end else if (st == 3'd2) begin
            if (cls <= 3'd3) begin
                aluwe = 1'b1;
                if (cls != 3'd0) begin imm = 1'b1; op2 = 2'd1; end
                if (cls <= 3'd1) srn = 1'b1;
            end else if (cls == 3'd4) begin
                if (cond_true(ir[11:9], flags)) begin pcwe = 1'b1; pcs = 3'd1; end
            end else if (cls == 3'd5) begin
                pcwe = 1'b1; pcs = 3'd1; lrwe = 1'b1;
            end else if (cls == 3'd6) begin
                pcwe = 1'b1; pcs = 3'd2;
            end
        end else if (st == 3'd3) begin
            aluen = 1'b1;
            if (cls == 3'd2) begin
                mr = 1'b1;
                if (ack) begin rgwe = 1'b1; rws = 2'd1; end
            end else mw = 1'b1;
        end else if (st == 3'd4) begin
            rgwe = 1'b1; aluen = 1'b1;
        end else if (st == 3'd5) begin
            lrwe = 1'b1; pcwe = 1'b1; pcs = 3'd3; iack = 1'b1;
        end
        return {iack, irwe, pcwe, rgwe, aluwe, aluen, lrwe, srn, imm, mr, mw, pcs, rws, op2, st};
    endfunction

    // advance the model one clock using the inputs held over the edge
    always @(posedge clk) begin : model_step
        int np;
        bit nh, ni, ne, done;
        np = m_pos; nh = m_halt; ni = 1'b0; ne = m_ie; done = 1'b0;
        if (rst) begin
            np = 0; nh = 1'b0; ne = 1'b1;
        end else if (m_irq) begin
            np = 0; ne = 1'b0;
        end else if (m_halt) begin
            if (irq_now() && m_ie) begin ni = 1'b1; nh = 1'b0; np = 0; end
        end else begin
            case (m_pos)
                0: if (ack) np = 1;
                1: np = 2;
                2: begin
                    case (ir[15:13])
                        3'd0, 3'd1, 3'd2, 3'd3: np = 3;
                        3'd6: begin done = 1'b1; if (ir[0]) ne = 1'b1; end
                        3'd7: nh = 1'b1;
                        default: done = 1'b1;
                    endcase
                end
                default: if (ir[15:14] == 2'b00 || ack) done = 1'b1;
            endcase
            if (done) begin
                np = 0;
                if (irq_now() && m_ie) ni = 1'b1;
            end
        end
        m_pos  <= np;
        m_halt <= nh;
        m_irq  <= ni;
        m_ie   <= ne;
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        n_checks++;
        if (dut_v !== exp_vec()) begin
            n_errors++;
            $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, dut_v, exp_vec());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    task automatic run_instr(input logic [15:0] i_val, input logic [3:0] f_val, input int waits);
        int w;
        bit done;
        w = 0; done = 1'b0;
        ir = i_val; flags = f_val; ack = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            step();
            if (exp_state() == 3'd3) begin
                ack = (w >= waits);
                w++;
            end else ack = 1'b1;
            if (exp_state() == 3'd0) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL run_instr_timeout ir=%h actual_state=%0d required=0", i_val, state);
        end
    endtask

    initial begin
        // reset held for two edges, released with MemAck=1 and Ir=0
        rst = 1'b1; ir = 16'h0000; ack = 1'b1;
        step(); peek(); chk("rst_quiet_1", 32'(dut_v), 0);
        step(); peek(); chk("rst_quiet_2", 32'(dut_v), 0);
        rst = 1'b0;
        peek(); chk("alu_st0", 32'(state), 0); chk("alu_fetch_irwe", 32'(ir_we), 1);
        step(); peek(); chk("alu_st1", 32'(state), 1);
        step(); peek(); chk("alu_st2", 32'(state), 2); chk("alu_aluwe", 32'(alu_we), 1);
        step(); peek(); chk("alu_st4", 32'(state), 4); chk("alu_regwe", 32'(reg_we), 1);
        step(); ir = 16'h4000;
        peek(); chk("alu_back0", 32'(state), 0);

        // load with three wait cycles in MEM
        step(); step(); peek(); chk("ld_exec_op2", 32'(op2_sel), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            ack = (i == 3);
            peek();
            chk("ld_mem_state", 32'(state), 3);
            chk("ld_memread", 32'(mem_read), 1);
            chk("ld_regwe", 32'(reg_we), (i == 3) ? 1 : 0);
            chk("ld_rwsel", 32'(rw_sel), (i == 3) ? 1 : 0);
            step();
        end
        peek(); chk("ld_back0", 32'(state), 0);

        // Bcc on Z, taken then not taken
        ir = 16'h8200; flags = 4'b0100;
        step(); step(); peek();
        chk("bz_taken_pcwe", 32'(pc_we), 1); chk("bz_taken_pcsel", 32'(pc_sel), 1);
        step(); peek(); chk("bz_taken_back0", 32'(state), 0);
        flags = 4'b0000;
        step(); step(); peek(); chk("bz_nt_pcwe", 32'(pc_we), 0);
        step(); peek(); chk("bz_nt_back0", 32'(state), 0);

        // reset in store MEM with MemAck pending
        ir = 16'h6000;
        step(); step(); step();
        rst = 1'b1; ack = 1'b1;
        peek();
        chk("st_rst_memwrite", 32'(mem_write), 0); chk("st_rst_pcwe", 32'(pc_we), 0);
        chk("st_rst_state", 32'(state), 0);
        step(); rst = 1'b0;
        peek(); chk("st_rst_next", 32'(state), 0);

        // fetch wait states
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("fw_state", 32'(state), 0); chk("fw_irwe", 32'(ir_we), 0);
            chk("fw_memread", 32'(mem_read), 1);
            step();
        end

        // sweep of classes, conditions and wait counts against the model
        run_instr(16'h0000, 4'hF, 0);
        run_instr(16'h2000, 4'h0, 0);
        run_instr(16'h4000, 4'h0, 1);
        run_instr(16'h6000, 4'h0, 0);
        run_instr(16'h6000, 4'h0, 2);
        run_instr(16'hA000, 4'h0, 0);
        run_instr(16'hC000, 4'h0, 0);
        for (int c = 0; c < 8; c++) begin
            run_instr({3'b100, 1'b0, 3'(c), 9'd0}, 4'hF, 0);
            run_instr({3'b100, 1'b0, 3'(c), 9'd0}, 4'h0, 0);
            run_instr({3'b100, 1'b0, 3'(c), 9'd0}, 4'(c * 5 + 3), 0);
        end

        // halt
        ir = 16'hE000; ack = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 20; i++) begin
            peek();
            chk("halt_state", 32'(state), 6);
            chk("halt_quiet", 32'(dut_v[20:3]), 0);
            step();
        end
`ifdef CONTROL_FSM_IRQ_EN
        irq = 1'b1;
        step(); peek();
        chk("irq_state", 32'(state), 5); chk("irq_ack", 32'(irq_ack), 1);
        chk("irq_pcsel", 32'(pc_sel), 3); chk("irq_lrwe", 32'(lr_we), 1);
        ir = 16'hC001;
        step(); peek(); chk("irq_to_fetch", 32'(state), 0);
        step(); step(); peek(); chk("reti_pcsel", 32'(pc_sel), 2);
        step(); peek(); chk("irq2_ignored", 32'(state), 0);
        ir = 16'h8000;
        step(); step(); step(); peek(); chk("irq_after_reti", 32'(state), 5);
        irq = 1'b0;
        step(); peek(); chk("irq2_to_fetch", 32'(state), 0);
`else
        rst = 1'b1;
        step(); rst = 1'b0;
        peek(); chk("halt_rst_exit", 32'(state), 0);
`endif
        run_instr(16'h2000, 4'h0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
